// File: rtl/sap1_sequencer_if.sv
// Control and status bundle between the SAP-1 sequencer and the datapath it drives.
interface sap1_sequencer_if;
  logic       run;
  logic       step_mode;
  logic       step;
  logic [3:0] ir_op;
  logic [5:0] t;
  logic       cp;
  logic       ep;
  logic       ea;
  logic       su;
  logic       eu;
  logic       n_lm;
  logic       n_ce;
  logic       n_l1;
  logic       n_e1;
  logic       n_la;
  logic       n_lb;
  logic       n_l0;
  logic       n_hlt;
  logic       halted;
  logic       instr_done;

  modport master (
    input  run, step_mode, step, ir_op,
    output t, cp, ep, ea, su, eu, n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0, n_hlt,
    output halted, instr_done
  );

  modport slave (
    output run, step_mode, step, ir_op,
    input  t, cp, ep, ea, su, eu, n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0, n_hlt,
    input  halted, instr_done
  );
endinterface

// File: rtl/sap1_sequencer.sv
// SAP-1 T-state sequencer: T1..T6 ring plus HALT, with run/stop gating,
// single-step mode and optional early return to T1 after the last active T-state.
module sap1_sequencer #(
  parameter bit FAST_NOP = 1'b0
) (
  input logic              clk,
  input logic              n_clr,
  sap1_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state_reg, state_next;
  logic   step_q_reg;
  logic   adv;
  logic   last_t;

  always_ff @(posedge clk) begin
    if (!n_clr) begin
      state_reg  <= ST_T1;
      step_q_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      step_q_reg <= bus.step;
    end
  end

  // step_q resets high, so a step level held through reset is not seen as a rising edge.
  assign adv = bus.run & (bus.step_mode ? (bus.step & ~step_q_reg) : 1'b1)
             & (state_reg != ST_HALT);

  always_comb begin
    last_t = 1'b0;
    if (!FAST_NOP) begin
      last_t = (state_reg == ST_T6);
    end else begin
      case (bus.ir_op)
        OP_LDA:         last_t = (state_reg == ST_T5);
        OP_ADD, OP_SUB: last_t = (state_reg == ST_T6);
        OP_HLT:         last_t = 1'b0;
        default:        last_t = (state_reg == ST_T4);
      endcase
    end
  end

  always_comb begin
    case (state_reg)
      ST_T1:   bus.t = 6'b000001;
      ST_T2:   bus.t = 6'b000010;
      ST_T3:   bus.t = 6'b000100;
      ST_T4:   bus.t = 6'b001000;
      ST_T5:   bus.t = 6'b010000;
      ST_T6:   bus.t = 6'b100000;
      default: bus.t = 6'b000000;
    endcase
  end

  // Controls are only driven on an advancing cycle so a waiting step never repeats a load.
  always_comb begin
    state_next     = state_reg;
    bus.cp         = 1'b0;
    bus.ep         = 1'b0;
    bus.ea         = 1'b0;
    bus.su         = 1'b0;
    bus.eu         = 1'b0;
    bus.n_lm       = 1'b1;
    bus.n_ce       = 1'b1;
    bus.n_l1       = 1'b1;
    bus.n_e1       = 1'b1;
    bus.n_la       = 1'b1;
    bus.n_lb       = 1'b1;
    bus.n_l0       = 1'b1;
    bus.n_hlt      = (state_reg != ST_HALT);
    bus.halted     = (state_reg == ST_HALT);
    bus.instr_done = adv & last_t;
    if (adv) begin
      case (state_reg)
        ST_T1: begin
          bus.ep     = 1'b1;
          bus.n_lm   = 1'b0;
          state_next = ST_T2;
        end
        ST_T2: begin
          bus.cp     = 1'b1;
          state_next = ST_T3;
        end
        ST_T3: begin
          bus.n_ce   = 1'b0;
          bus.n_l1   = 1'b0;
          state_next = ST_T4;
        end
        ST_T4: begin
          state_next = last_t ? ST_T1 : ST_T5;
          case (bus.ir_op)
            OP_LDA, OP_ADD, OP_SUB: begin
              bus.n_lm = 1'b0;
              bus.n_e1 = 1'b0;
            end
            OP_OUT: begin
              bus.ea   = 1'b1;
              bus.n_l0 = 1'b0;
            end
            OP_HLT: begin
              bus.n_hlt  = 1'b0;
              state_next = ST_HALT;
            end
            default: ;
          endcase
        end
        ST_T5: begin
          state_next = last_t ? ST_T1 : ST_T6;
          case (bus.ir_op)
            OP_LDA: begin
              bus.n_ce = 1'b0;
              bus.n_la = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              bus.n_ce = 1'b0;
              bus.n_lb = 1'b0;
            end
            default: ;
          endcase
        end
        ST_T6: begin
          state_next = ST_T1;
          if (bus.ir_op == OP_ADD || bus.ir_op == OP_SUB) begin
            bus.eu   = 1'b1;
            bus.n_la = 1'b0;
            bus.su   = (bus.ir_op == OP_SUB);
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_sap1_sequencer.sv
// Bench for sap1_sequencer: two instances (FAST_NOP = 0 and 1) checked every cycle
// against a microcode-table model, plus directed literal checks from the test plan.
module tb_sap1_sequencer;
  logic clk = 1'b0;
  logic n_clr = 1'b0;
  logic run = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;

  int checks = 0;
  int failures = 0;

  sap1_sequencer_if b0();
  sap1_sequencer_if b1();

  // Asserted-control bit positions, in the order {cp,ep,ea,su,eu,lm,ce,l1,e1,la,lb,l0,hlt}.
  localparam logic [12:0] B_CP = 13'h1000, B_EP = 13'h0800, B_EA = 13'h0400, B_SU = 13'h0200;
  localparam logic [12:0] B_EU = 13'h0100, B_LM = 13'h0080, B_CE = 13'h0040, B_L1 = 13'h0020;
  localparam logic [12:0] B_E1 = 13'h0010, B_LA = 13'h0008, B_LB = 13'h0004, B_L0 = 13'h0002;
  localparam logic [12:0] B_HLT = 13'h0001;
  localparam logic [12:0] LOW_MASK = 13'h00FF;

  logic [12:0] ucode [6][6];
  logic [3:0]  prog [2][9];
  int          m_t [2];
  logic        m_sq [2];
  logic        need_load [2];
  int          idx [2];
  logic [3:0]  m_op [2];
  logic [1:0][20:0] obs;

  assign b0.run = run;
  assign b1.run = run;
  assign b0.step_mode = step_mode;
  assign b1.step_mode = step_mode;
  assign b0.step = step;
  assign b1.step = step;
  assign b0.ir_op = m_op[0];
  assign b1.ir_op = m_op[1];

  assign obs[0] = {b0.t, b0.cp, b0.ep, b0.ea, b0.su, b0.eu, b0.n_lm, b0.n_ce, b0.n_l1,
                   b0.n_e1, b0.n_la, b0.n_lb, b0.n_l0, b0.n_hlt, b0.halted, b0.instr_done};
  assign obs[1] = {b1.t, b1.cp, b1.ep, b1.ea, b1.su, b1.eu, b1.n_lm, b1.n_ce, b1.n_l1,
                   b1.n_e1, b1.n_la, b1.n_lb, b1.n_l0, b1.n_hlt, b1.halted, b1.instr_done};

  sap1_sequencer #(.FAST_NOP(1'b0)) u_dut0 (.clk(clk), .n_clr(n_clr), .bus(b0));
  sap1_sequencer #(.FAST_NOP(1'b1)) u_dut1 (.clk(clk), .n_clr(n_clr), .bus(b1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction class: 0 LDA, 1 ADD, 2 SUB, 3 OUT, 4 HLT, 5 NOP.
  function automatic int cls(input logic [3:0] op);
    case (op)
      4'd0:    return 0;
      4'd1:    return 1;
      4'd2:    return 2;
      4'd14:   return 3;
      4'd15:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int ilen(input logic [3:0] op, input bit fast);
    if (!fast) return 6;
    case (cls(op))
      0:       return 5;
      1, 2, 4: return 6;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_adv(input int k);
    return (m_t[k] != 0) && run && (step_mode ? (step && !m_sq[k]) : 1'b1);
  endfunction

  function automatic logic [20:0] expect_word(input int k);
    logic [12:0] act;
    logic [5:0]  tv;
    logic        halt;
    logic        done;
    halt = (m_t[k] == 0);
    act  = '0;
    tv   = '0;
    done = 1'b0;
    if (halt) begin
      act = B_HLT;
    end else begin
      tv = 6'(1 << (m_t[k] - 1));
      if (model_adv(k)) begin
        act  = ucode[cls(m_op[k])][m_t[k] - 1];
        done = (m_t[k] == ilen(m_op[k], k == 1));
      end
    end
    return {tv, act ^ LOW_MASK, halt, done};
  endfunction

  initial begin
    for (int c = 0; c < 6; c++) begin
      ucode[c][0] = B_EP | B_LM;
      ucode[c][1] = B_CP;
      ucode[c][2] = B_CE | B_L1;
      for (int s = 3; s < 6; s++) ucode[c][s] = '0;
    end
    ucode[0][3] = B_LM | B_E1;
    ucode[0][4] = B_CE | B_LA;
    for (int c = 1; c < 3; c++) begin
      ucode[c][3] = B_LM | B_E1;
      ucode[c][4] = B_CE | B_LB;
      ucode[c][5] = B_EU | B_LA;
    end
    ucode[2][5] = B_EU | B_LA | B_SU;
    ucode[3][3] = B_EA | B_L0;
    ucode[4][3] = B_HLT;
    prog[0] = '{4'd1, 4'd5, 4'd0, 4'd2, 4'd14, 4'd0, 4'd1, 4'd2, 4'd15};
    prog[1] = '{4'd2, 4'd14, 4'd0, 4'd5, 4'd1, 4'd14, 4'd2, 4'd15, 4'd15};
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 1;
      m_sq[k] = 1'b1;
      need_load[k] = 1'b1;
      idx[k] = -1;
      m_op[k] = 4'd0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!n_clr) begin
        m_t[k] = 1;
        m_sq[k] = 1'b1;
        need_load[k] = 1'b1;
      end else begin
        if (model_adv(k)) begin
          if (m_t[k] == 4 && cls(m_op[k]) == 4) begin
            m_t[k] = 0;
          end else if (m_t[k] == ilen(m_op[k], k == 1)) begin
            m_t[k] = 1;
            need_load[k] = 1'b1;
          end else begin
            m_t[k] = m_t[k] + 1;
          end
        end
        m_sq[k] = step;
      end
    end
  end

  always @(negedge clk) begin
    if (n_clr) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d_word", k), int'(obs[k]), int'(expect_word(k)));
        if (obs[k][0]) $display("dut%0d instr op=%h complete at %0t", k, m_op[k], $time);
        if (need_load[k] && m_t[k] == 1) begin
          if (idx[k] < 8) idx[k] = idx[k] + 1;
          m_op[k] = prog[k][idx[k]];
          need_load[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [5:0] exp_t0 [13] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01,
                               6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
  logic [5:0] exp_t1 [11] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01,
                               6'h02, 6'h04, 6'h08, 6'h01};
  bit step_pat [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int   cp_cnt;
    int   adv_cnt;
    int   guard;
    bit   saw_hlt;
    logic [5:0] prev_t;

    repeat (2) @(posedge clk);
    #1;
    n_clr = 1'b1;
    run = 1'b1;

    // Free-run: dut0 ADD then NOP 0101; dut1 SUB then OUT.
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("t_ring_dut0", int'(b0.t), int'(exp_t0[c]));
      if (c < 11) chk("t_ring_dut1", int'(b1.t), int'(exp_t1[c]));
      if (c == 4) chk("add_t5_n_lb", int'(b0.n_lb), 0);
      if (c == 5) begin
        chk("add_t6_eu", int'(b0.eu), 1);
        chk("add_t6_n_la", int'(b0.n_la), 0);
        chk("add_t6_su", int'(b0.su), 0);
        chk("add_t6_done", int'(b0.instr_done), 1);
        chk("sub_t6_su", int'(b1.su), 1);
        chk("sub_t6_eu", int'(b1.eu), 1);
      end
      if (c == 4) chk("add_t5_done", int'(b0.instr_done), 0);
      if (c == 9) begin
        chk("out_t4_ea", int'(b1.ea), 1);
        chk("out_t4_n_l0", int'(b1.n_l0), 0);
        chk("out_t4_done", int'(b1.instr_done), 1);
      end
      if (c == 11) begin
        chk("nop_t6_done", int'(b0.instr_done), 1);
        chk("nop_t6_n_la", int'(b0.n_la), 1);
        chk("nop_t6_eu", int'(b0.eu), 0);
      end
    end

    // Pause at T3.
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (b0.t != 6'h02 && guard < 20);
    chk("wait_t2_timeout", int'(guard < 20), 1);
    @(posedge clk);
    #1;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_t", int'(b0.t), 6'h04);
      chk("pause_n_ce", int'(b0.n_ce), 1);
      chk("pause_cp", int'(b0.cp), 0);
    end
    @(posedge clk);
    #1;
    run = 1'b1;
    @(negedge clk);
    chk("resume_n_ce", int'(b0.n_ce), 0);
    chk("resume_n_l1", int'(b0.n_l1), 0);

    // Reset during T5.
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (b0.t != 6'h08 && guard < 20);
    chk("wait_t4_timeout", int'(guard < 20), 1);
    @(posedge clk);
    #1;
    chk("pre_reset_t5", int'(b0.t), 6'h10);
    n_clr = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    n_clr = 1'b1;
    @(negedge clk);
    chk("reset_t_dut0", int'(b0.t), 6'h01);
    chk("reset_t_dut1", int'(b1.t), 6'h01);
    chk("reset_idle_ep", int'(b0.ep), 0);
    chk("reset_idle_n_lm", int'(b0.n_lm), 1);
    chk("reset_halted", int'(b0.halted), 0);

    // Step mode: high 5, low 3, high 1.
    @(posedge clk);
    #1;
    step_mode = 1'b1;
    run = 1'b1;
    cp_cnt = 0;
    adv_cnt = 0;
    prev_t = 6'h01;
    for (int i = 0; i < 12; i++) begin
      step = step_pat[i];
      @(negedge clk);
      cp_cnt += int'(b0.cp);
      if (b0.t != prev_t) adv_cnt++;
      prev_t = b0.t;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    if (b0.t != prev_t) adv_cnt++;
    chk("step_cp_count", cp_cnt, 1);
    chk("step_adv_count", adv_cnt, 2);
    chk("step_final_t", int'(b0.t), 6'h04);
    chk("step_final_t_dut1", int'(b1.t), 6'h04);

    // Step held high through reset must not advance until re-raised.
    @(posedge clk);
    #1;
    step = 1'b1;
    n_clr = 1'b0;
    @(posedge clk);
    #1;
    n_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_step_t", int'(b0.t), 6'h01);
      chk("held_step_ep", int'(b0.ep), 0);
      @(posedge clk);
      #1;
    end
    step = 1'b0;
    @(posedge clk);
    #1;
    step = 1'b1;
    @(negedge clk);
    chk("restep_ep", int'(b0.ep), 1);
    @(posedge clk);
    #1;
    step = 1'b0;
    step_mode = 1'b0;
    @(negedge clk);
    chk("restep_t", int'(b0.t), 6'h02);
    chk("freerun_cp", int'(b0.cp), 1);

    // Free-run to HLT on both instances.
    saw_hlt = 1'b0;
    guard = 0;
    while (!(b0.halted && b1.halted) && guard < 500) begin
      @(negedge clk);
      if (b0.t == 6'h08 && b0.n_hlt == 1'b0) saw_hlt = 1'b1;
      guard++;
    end
    chk("halt_timeout", int'(guard < 500), 1);
    chk("hlt_t4_n_hlt", int'(saw_hlt), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      run = 1'b1;
      step = i[0];
      step_mode = i[1];
      @(negedge clk);
      chk("halt_t", int'(b0.t), 0);
      chk("halt_halted", int'(b0.halted), 1);
      chk("halt_n_hlt", int'(b0.n_hlt), 0);
      chk("halt_t_dut1", int'(b1.t), 0);
    end
    @(posedge clk);
    #1;
    n_clr = 1'b0;
    run = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    @(posedge clk);
    #1;
    n_clr = 1'b1;
    @(negedge clk);
    chk("unhalt_t", int'(b0.t), 6'h01);
    chk("unhalt_halted", int'(b0.halted), 0);
    chk("unhalt_t_dut1", int'(b1.t), 6'h01);
    chk("unhalt_n_hlt", int'(b1.n_hlt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
